// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// Shared 4-bit ripple-carry adder used by the serial controller datapath.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic c;

    always_comb begin
        s = '0;
        c = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per cycle through a shared adder4.
//   state | meaning
//   IDLE  | waiting for Start; result registers hold last value
//   RUN   | one nibble per cycle, LS nibble first
//   DONE  | one-cycle Done pulse, then back to IDLE
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    input  logic                    Sub,
    input  logic [NIBBLE_W*NIBBLES-1:0] A,
    input  logic [NIBBLE_W*NIBBLES-1:0] B,
    output logic                    Busy,
    output logic                    Done,
    output logic [NIBBLE_W*NIBBLES-1:0] Sum,
    output logic                    Cout,
    output logic                    Ovf
);

    localparam int WIDTH = NIBBLE_W * NIBBLES;
    localparam int MSB   = WIDTH - 1;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               state;
    state_t               state_nx;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic                 carry_r;
    logic [IDX_W-1:0]     idx;
    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  s_nib;
    logic                 c_out;
    logic                 last;

    assign a_nib = a_r[int'(idx)*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_r[int'(idx)*NIBBLE_W +: NIBBLE_W];
    assign last  = (idx == LAST_IDX);

    adder4 u_adder4 (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry_r),
        .s     (s_nib),
        .c_out (c_out)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: invert B once at accept and seed the carry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_r     <= A;
                        b_r     <= Sub ? ~B : B;
                        carry_r <= Sub;
                        idx     <= '0;
                        Sum     <= '0;
                        Cout    <= 1'b0;
                        Ovf     <= 1'b0;
                    end
                end
                RUN: begin
                    Sum[int'(idx)*NIBBLE_W +: NIBBLE_W] <= s_nib;
                    carry_r <= c_out;
                    if (last) begin
                        Cout <= c_out;
                        Ovf  <= (a_r[MSB] == b_r[MSB]) && (s_nib[NIBBLE_W-1] != a_r[MSB]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule
